mem_access_unit: RTL and testbench

- Initiator side of the 256x32 data-memory interface.
- Accepts byte/half/word load and store requests from the CPU pipeline and turns them into word-addressed memory cycles on mem_we/mem_address/mem_dataIn/mem_dataOut.
- Handles lane selection, sign/zero extension and read-modify-write for sub-word stores.
- The memory writes on the falling edge and returns read data combinationally.

---
 rtl/mem_access_unit.sv | 145 ++++++++++++++
 tb/tb_mem_access_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Initiator side of a word-addressed data memory: byte/half/word loads and stores,
// sub-word stores via read-modify-write. Optional macro MEM_MISALIGN_TRAP_EN traps misaligned half/word.
module mem_access_unit #(
  parameter int MEM_AW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [MEM_AW+1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_address,
  output logic [31:0]       mem_dataIn,
  input  logic [31:0]       mem_dataOut
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state;
  logic        store_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        req_err;
  logic        accept;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // Requests that complete immediately as errors, never touching memory.
  always_comb begin
    req_err = (req_size == 2'b11);
`ifdef MEM_MISALIGN_TRAP_EN
    if (req_size == 2'b01 && req_addr[0])
      req_err = 1'b1;
    if (req_size == 2'b10 && req_addr[1:0] != 2'b00)
      req_err = 1'b1;
`endif
  end

  function automatic logic [31:0] format_load(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace only the addressed lane; the other lanes are written back untouched.
  function automatic logic [31:0] merge_store(input logic [31:0] w, input logic [1:0] sz,
                                              input logic [1:0] lane, input logic [15:0] d);
    logic [31:0] r;
    r = w;
    if (sz == 2'b00)
      r[{lane, 3'b000} +: 8] = d[7:0];
    else
      r[{lane[1], 4'b0000} +: 16] = d;
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      store_q     <= 1'b0;
      uns_q       <= 1'b0;
      size_q      <= 2'b00;
      lane_q      <= 2'b00;
      wdata_q     <= 16'b0;
      resp_valid  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= 32'b0;
      mem_we      <= 1'b0;
      mem_address <= '0;
      mem_dataIn  <= 32'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            store_q     <= req_store;
            uns_q       <= req_unsigned;
            size_q      <= req_size;
            lane_q      <= req_addr[1:0];
            wdata_q     <= req_wdata[15:0];
            mem_address <= req_addr[MEM_AW+1:2];
            if (req_err) begin
              state      <= DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'b0;
            end else if (req_store && req_size == 2'b10) begin
              state      <= WRITE;
              mem_we     <= 1'b1;
              mem_dataIn <= req_wdata;
            end else begin
              state <= READ;
            end
          end
        end
        // The only cycle in which the combinational read data is sampled.
        READ: begin
          if (store_q) begin
            mem_dataIn <= merge_store(mem_dataOut, size_q, lane_q, wdata_q);
            mem_we     <= 1'b1;
            state      <= WRITE;
          end else begin
            resp_rdata <= format_load(mem_dataOut, size_q, lane_q, uns_q);
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= DONE;
          end
        end
        WRITE: begin
          mem_we     <= 1'b0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= 32'b0;
          state      <= DONE;
        end
        DONE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= 32'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a falling-edge-write memory model.
// Expectations for misaligned accesses follow MEM_MISALIGN_TRAP_EN when defined.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [7:0]  mem_address;
  logic [31:0] mem_dataIn;
  logic [31:0] mem_dataOut;

  logic [31:0] mem [256];
  int testsRun  = 0;
  int failCount = 0;

  mem_access_unit #(.MEM_AW(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .mem_we(mem_we), .mem_address(mem_address),
    .mem_dataIn(mem_dataIn), .mem_dataOut(mem_dataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory writes on the falling edge and reads combinationally.
  always @(negedge clk)
    if (mem_we) mem[mem_address] <= mem_dataIn;
  assign mem_dataOut = mem[mem_address];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input string tag, input logic st, input logic [1:0] sz,
                               input logic un, input logic [9:0] ad, input logic [31:0] wd,
                               input int expLat, input logic [31:0] expRdata, input logic expErr,
                               input int expWe, input logic [31:0] expWdata);
    int lat = 0;
    int weCount = 0;
    logic got = 1'b0;
    logic [31:0] rdata = 32'b0;
    logic err = 1'b0;
    logic [7:0] weAddr = 8'b0;
    logic [31:0] weData = 32'b0;
    @(negedge clk);
    req_store = st; req_size = sz; req_unsigned = un; req_addr = ad; req_wdata = wd;
    req_valid = 1'b1;
    checkOutput({tag, ":ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    while (lat < 8 && !got) begin
      @(negedge clk);
      lat++;
      if (mem_we) begin
        weCount++;
        weAddr = mem_address;
        weData = mem_dataIn;
      end
      if (resp_valid) begin
        got = 1'b1;
        rdata = resp_rdata;
        err = resp_err;
      end
    end
    checkOutput({tag, ":resp_seen"}, 32'(got), 32'd1);
    checkOutput({tag, ":latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, ":rdata"}, rdata, expRdata);
    checkOutput({tag, ":err"}, 32'(err), 32'(expErr));
    checkOutput({tag, ":we_cycles"}, 32'(weCount), 32'(expWe));
    if (expWe != 0) begin
      checkOutput({tag, ":we_addr"}, 32'(weAddr), 32'(ad[9:2]));
      checkOutput({tag, ":we_data"}, weData, expWdata);
    end
    @(negedge clk);
    checkOutput({tag, ":valid_drop"}, 32'(resp_valid), 32'd0);
    checkOutput({tag, ":rdata_drop"}, resp_rdata, 32'd0);
  endtask

  initial begin
    int weSeen;
    int respSeen;
    for (int i = 0; i < 256; i++) mem[i] = 32'b0;
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 10'b0; req_wdata = 32'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst:ready", 32'(req_ready), 32'd0);
    checkOutput("rst:valid", 32'(resp_valid), 32'd0);
    checkOutput("rst:err", 32'(resp_err), 32'd0);
    checkOutput("rst:we", 32'(mem_we), 32'd0);
    checkOutput("rst:addr", 32'(mem_address), 32'd0);
    checkOutput("rst:rdata", resp_rdata, 32'd0);
    checkOutput("rst:dataIn", mem_dataIn, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst:ready_after", 32'(req_ready), 32'd1);

    // Word store then word load
    applyStimulus("sw", 1'b1, 2'b10, 1'b0, 10'h010, 32'hDEADBEEF, 2, 32'h0, 1'b0, 1, 32'hDEADBEEF);
    checkOutput("sw:mem4", mem[4], 32'hDEADBEEF);
    applyStimulus("lw", 1'b0, 2'b10, 1'b0, 10'h010, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0, 32'h0);

    // Byte store read-modify-write
    mem[4] = 32'h11223344;
    applyStimulus("sb", 1'b1, 2'b00, 1'b0, 10'h012, 32'h000000AB, 3, 32'h0, 1'b0, 1, 32'h11AB3344);
    checkOutput("sb:mem4", mem[4], 32'h11AB3344);

    // Loads with extension
    mem[4] = 32'h80FF7F01;
    applyStimulus("lb_s2", 1'b0, 2'b00, 1'b0, 10'h012, 32'h0, 2, 32'hFFFFFFFF, 1'b0, 0, 32'h0);
    applyStimulus("lb_u2", 1'b0, 2'b00, 1'b1, 10'h012, 32'h0, 2, 32'h000000FF, 1'b0, 0, 32'h0);
    applyStimulus("lh_s1", 1'b0, 2'b01, 1'b0, 10'h012, 32'h0, 2, 32'hFFFF80FF, 1'b0, 0, 32'h0);
    applyStimulus("lh_u0", 1'b0, 2'b01, 1'b1, 10'h010, 32'h0, 2, 32'h00007F01, 1'b0, 0, 32'h0);
    applyStimulus("lb_s1", 1'b0, 2'b00, 1'b0, 10'h011, 32'h0, 2, 32'h0000007F, 1'b0, 0, 32'h0);
    applyStimulus("lb_s3", 1'b0, 2'b00, 1'b0, 10'h013, 32'h0, 2, 32'hFFFFFF80, 1'b0, 0, 32'h0);

    // Half store to upper lane
    applyStimulus("sh", 1'b1, 2'b01, 1'b0, 10'h012, 32'hFFFF1234, 3, 32'h0, 1'b0, 1, 32'h12347F01);
    checkOutput("sh:mem4", mem[4], 32'h12347F01);

    // Reserved size
    applyStimulus("rsv_ld", 1'b0, 2'b11, 1'b0, 10'h010, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0);
    applyStimulus("rsv_st", 1'b1, 2'b11, 1'b0, 10'h010, 32'h55555555, 1, 32'h0, 1'b1, 0, 32'h0);
    checkOutput("rsv_st:mem4", mem[4], 32'h12347F01);

    // Misaligned accesses
`ifdef MEM_MISALIGN_TRAP_EN
    applyStimulus("lw_mis", 1'b0, 2'b10, 1'b0, 10'h013, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0);
    applyStimulus("lh_mis", 1'b0, 2'b01, 1'b0, 10'h011, 32'h0, 1, 32'h0, 1'b1, 0, 32'h0);
    applyStimulus("sw_mis", 1'b1, 2'b10, 1'b0, 10'h011, 32'h99999999, 1, 32'h0, 1'b1, 0, 32'h0);
    checkOutput("sw_mis:mem4", mem[4], 32'h12347F01);
`else
    applyStimulus("lw_mis", 1'b0, 2'b10, 1'b0, 10'h013, 32'h0, 2, 32'h12347F01, 1'b0, 0, 32'h0);
    applyStimulus("lh_mis", 1'b0, 2'b01, 1'b0, 10'h011, 32'h0, 2, 32'h00007F01, 1'b0, 0, 32'h0);
`endif

    // Reset while a half store sits in READ
    mem[4] = 32'hCAFEF00D;
    @(negedge clk);
    req_store = 1'b1; req_size = 2'b01; req_unsigned = 1'b0; req_addr = 10'h012;
    req_wdata = 32'h0000BEEF; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    weSeen = 0; respSeen = 0;
    @(negedge clk);
    if (mem_we) weSeen++;
    if (resp_valid) respSeen++;
    checkOutput("rstmid:ready_in_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1 checkOutput("rstmid:ready_after", 32'(req_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_we) weSeen++;
      if (resp_valid) respSeen++;
    end
    checkOutput("rstmid:we_seen", 32'(weSeen), 32'd0);
    checkOutput("rstmid:resp_seen", 32'(respSeen), 32'd0);
    checkOutput("rstmid:mem4", mem[4], 32'hCAFEF00D);

    // req_valid held high: exactly one accept per transaction
    @(negedge clk);
    req_store = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 10'h010;
    req_valid = 1'b1;
    checkOutput("b2b:ready0", 32'(req_ready), 32'd1);
    @(negedge clk);
    checkOutput("b2b:ready_read", 32'(req_ready), 32'd0);
    checkOutput("b2b:valid_read", 32'(resp_valid), 32'd0);
    @(negedge clk);
    checkOutput("b2b:ready_done", 32'(req_ready), 32'd0);
    checkOutput("b2b:valid_done", 32'(resp_valid), 32'd1);
    checkOutput("b2b:rdata", resp_rdata, 32'hCAFEF00D);
    @(negedge clk);
    checkOutput("b2b:ready_idle", 32'(req_ready), 32'd1);
    checkOutput("b2b:valid_idle", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b:second_read", 32'(req_ready), 32'd0);
    @(negedge clk);
    checkOutput("b2b:second_valid", 32'(resp_valid), 32'd1);
    checkOutput("b2b:second_rdata", resp_rdata, 32'hCAFEF00D);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
